flag_unit: RTL and testbench
============================

// Module: flag_unit
// PURPOSE
//  Producer of the fZero/fSign/fCarry condition flags consumed by branch_control.
//  Latches flags from ALU results according to opcode class and tracks in-flight ALU ops.
//  Raises flags_ready only when no flag-setting result is outstanding.
//  Saves flags on call and restores them on return through a small LIFO stack.
// PARAMETERS
//  DATA_W       32  ALU result width
//  STACK_DEPTH   4  flag-save stack entries (power of 2, >=2)
//  MAX_PEND      3  max outstanding issued ALU ops (pend counter width = clog2(MAX_PEND+1))
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  issue_alu    in   1       ALU op issued this cycle; its flags become pending
//  alu_valid    in   1       ALU result present this cycle
//  alu_opcode   in   6       opcode of the completing result
//  alu_result   in   DATA_W  ALU result
//  alu_carry    in   1       ALU carry-out / last bit shifted out
//  save_req     in   1       call: push current flags
//  restore_req  in   1       return: pop flags into flag register
//  fZero        out  1       zero flag (to branch_control)
//  fSign        out  1       sign flag
//  fCarry       out  1       carry flag
//  flags_ready  out  1       1 = no pending result; flags valid for branch resolution
//  stack_full   out  1       stack holds STACK_DEPTH entries
//  stack_empty  out  1       stack holds 0 entries
//  err          out  1       sticky: overflow, underflow, pend overflow/underflow, save&restore clash
// BEHAVIOUR
//  Reset (async, rst_n=0): fZero=fSign=fCarry=0, pend=0, flags_ready=1, sp=0,
//   stack_empty=1, stack_full=0, err=0. Stack contents are not reset.
//  Flag update, registered, 1-cycle latency (visible the cycle after alu_valid):
//   arith   alu_opcode[5:3]=000: Z=(result==0), S=result[DATA_W-1], C=alu_carry
//   logic   alu_opcode[5:3]=001: Z, S updated; C held
//   shift   alu_opcode[5:3]=010: Z, S updated; C=alu_carry
//   other classes: flags held (alu_valid still retires one pending op)
//  Pending counter: +1 on issue_alu, -1 on alu_valid; both in one cycle -> unchanged.
//   issue_alu at pend==MAX_PEND: increment dropped, err set.
//   alu_valid at pend==0 without issue_alu: flags still update, no decrement, err set.
//   flags_ready = (pend==0) (combinational from the register).
//  Stack: save_req pushes the registered flag value (pre-update); sp+1.
//   restore_req loads the top entry into the flags the next cycle; sp-1.
//   save at full or restore at empty: no state change, err set.
//   save_req & restore_req in the same cycle: both ignored, err set.
//   restore_req & flag-setting alu_valid in the same cycle: restore wins, ALU flag
//   update dropped; pending decrement still applies.
//   save_req & alu_valid in the same cycle: old flags pushed, new flags latched.
//  err clears only on reset.
// STRUCTURE
//  Shared package: opcode class constants (CLS_ARITH=3'b000, CLS_LOGIC=3'b001,
//   CLS_SHIFT=3'b010) and flags_t {z,s,c}; branch_control opcode constants belong there too.
//  One sub-module: flag_stack (LIFO of flags_t; push/pop/full/empty/err).
//  Top holds the flag register, the pending counter and the class decode.
// TESTING
//  1 reset mid-run (rst_n low with pend=2, sp=3) -> all flags 0, flags_ready=1, empty=1, err=0.
//  2 issue_alu; 1 cycle later alu_valid op=000001, result=0, carry=1
//     -> next cycle Z=1,S=0,C=1; flags_ready 0 while pending, 1 after.
//  3 C=1, logic op=001000, result=32'h8000_0000 -> Z=0,S=1,C=1 (held);
//     shift op=010000, carry=0 -> C=0.
//  4 flags {1,0,1}: save; arith sets {0,1,0}; restore -> {1,0,1} next cycle; empty=1.
//  5 push 4 times -> full=1; 5th save -> sp unchanged, err=1; 5 restores -> 5th sets
//     underflow err, flags = first pushed value.
//  6 restore_req & alu_valid(arith, result=0) same cycle -> flags = popped value;
//     pend decremented. save_req & restore_req same cycle -> err=1, sp unchanged.

Source files
------------

// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg: shared flag type, opcode class constants and branch opcodes
package flag_unit_pkg;
  localparam logic [2:0] CLS_ARITH = 3'b000;
  localparam logic [2:0] CLS_LOGIC = 3'b001;
  localparam logic [2:0] CLS_SHIFT = 3'b010;
  localparam logic [2:0] CLS_BRANCH = 3'b110;
  localparam logic [5:0] OP_BEQ = 6'b110000;
  localparam logic [5:0] OP_BNE = 6'b110001;
  localparam logic [5:0] OP_BLT = 6'b110010;
  localparam logic [5:0] OP_BGE = 6'b110011;
  localparam logic [5:0] OP_BCS = 6'b110100;
  localparam logic [5:0] OP_BCC = 6'b110101;
  localparam logic [5:0] OP_CALL = 6'b110110;
  localparam logic [5:0] OP_RET = 6'b110111;
  typedef struct packed {
    logic z;
    logic s;
    logic c;
  } flags_t;
endpackage

// File: rtl/flag_unit_stack.sv
// flag_stack: LIFO of saved flags with full/empty status and an illegal-access pulse
module flag_stack
  import flag_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t dout,
  output logic   full,
  output logic   empty,
  output logic   err
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] sp_q, sp_d;
  logic [AW-1:0] top_idx;
  flags_t mem [DEPTH];
  logic push_ok, pop_ok;
  assign full = sp_q == (AW+1)'(DEPTH);
  assign empty = sp_q == '0;
  assign push_ok = push & ~pop & ~full;
  assign pop_ok = pop & ~push & ~empty;
  assign err = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign dout = mem[top_idx];
  // next stack pointer: only legal single push or pop moves it
  always_comb begin
    sp_d = push_ok ? sp_q + 1'b1 : pop_ok ? sp_q - 1'b1 : sp_q;
  end
  // stack pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else sp_q <= sp_d;
  end
  // entry storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[sp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/flag_unit.sv
// flag_unit: condition flag register with pending-op tracking and call/return flag stack
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STACK_DEPTH = 4,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_alu,
  input  logic              alu_valid,
  input  logic [5:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              fZero,
  output logic              fSign,
  output logic              fCarry,
  output logic              flags_ready,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err
);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
  flags_t flags_q, flags_d, top_flags;
  logic [PW-1:0] pend_q, pend_d;
  logic err_q, err_d, stk_err, pend_err, restore_ok, sets_flags, unused_op;
  logic [2:0] cls;
  assign cls = alu_opcode[5:3];
  assign unused_op = ^alu_opcode[2:0];
  assign sets_flags = alu_valid & (cls == CLS_ARITH || cls == CLS_LOGIC || cls == CLS_SHIFT);
  assign restore_ok = restore_req & ~save_req & ~stack_empty;
  flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk  (clk),
    .rst_n(rst_n),
    .push (save_req),
    .pop  (restore_req),
    .din  (flags_q),
    .dout (top_flags),
    .full (stack_full),
    .empty(stack_empty),
    .err  (stk_err)
  );
  // a legal restore overrides any same-cycle ALU flag update; logic ops keep carry
  always_comb begin
    flags_d = flags_q;
    if (restore_ok) flags_d = top_flags;
    else if (sets_flags)
      flags_d = '{z: alu_result == '0, s: alu_result[DATA_W-1],
                  c: cls == CLS_LOGIC ? flags_q.c : alu_carry};
  end
  // pending count: simultaneous issue and retire cancel; saturate and flag misuse at the ends
  always_comb begin
    pend_d = pend_q;
    pend_err = 1'b0;
    if (issue_alu && !alu_valid) begin
      pend_err = pend_q == PMAX;
      pend_d = pend_err ? pend_q : pend_q + 1'b1;
    end else if (alu_valid && !issue_alu) begin
      pend_err = pend_q == '0;
      pend_d = pend_err ? pend_q : pend_q - 1'b1;
    end
    err_d = err_q | pend_err | stk_err;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      pend_q <= '0;
      err_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  assign fZero = flags_q.z;
  assign fSign = flags_q.s;
  assign fCarry = flags_q.c;
  assign flags_ready = pend_q == '0;
  assign err = err_q;
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed checks of flag update, pending tracking and flag stack
module tb_flag_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic issue_alu = 1'b0, alu_valid = 1'b0, alu_carry = 1'b0;
  logic save_req = 1'b0, restore_req = 1'b0;
  logic [5:0] alu_opcode = '0;
  logic [31:0] alu_result = '0;
  logic fZero, fSign, fCarry, flags_ready, stack_full, stack_empty, err;
  int n_cmp = 0;
  int n_bad = 0;

  flag_unit dut (
    .clk(clk), .rst_n(rst_n), .issue_alu(issue_alu), .alu_valid(alu_valid),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_carry(alu_carry),
    .save_req(save_req), .restore_req(restore_req), .fZero(fZero), .fSign(fSign),
    .fCarry(fCarry), .flags_ready(flags_ready), .stack_full(stack_full),
    .stack_empty(stack_empty), .err(err)
  );

  always #5 clk = ~clk;

  // observed vector: {Z,S,C,ready,full,empty,err}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {fZero, fSign, fCarry, flags_ready, stack_full, stack_empty, err};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got zsc_rdy_full_empty_err=%b expected %b", tag, obs, exp);
    end
  endtask

  // apply one cycle of inputs, then sample 1ns after the capturing edge
  task automatic cyc(input logic iss, input logic val, input logic [5:0] op,
                     input logic [31:0] res, input logic car, input logic sv, input logic rs);
    issue_alu = iss; alu_valid = val; alu_opcode = op; alu_result = res;
    alu_carry = car; save_req = sv; restore_req = rs;
    @(posedge clk); #1;
    issue_alu = 0; alu_valid = 0; alu_opcode = '0; alu_result = '0;
    alu_carry = 0; save_req = 0; restore_req = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 7'b0001010);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_state", 7'b0001010);
    // basic arith update with pending tracking
    cyc(1, 0, 6'b000000, 32'h0, 0, 0, 0);
    chk("pending_not_ready", 7'b0000010);
    cyc(0, 1, 6'b000001, 32'h0, 1, 0, 0);
    chk("arith_zero_carry", 7'b1011010);
    // logic holds carry, shift loads it, other class holds all
    cyc(1, 1, 6'b001000, 32'h8000_0000, 0, 0, 0);
    chk("logic_hold_c", 7'b0111010);
    cyc(1, 1, 6'b010000, 32'h8000_0000, 0, 0, 0);
    chk("shift_load_c", 7'b0101010);
    cyc(1, 1, 6'b011000, 32'h0, 1, 0, 0);
    chk("other_class_held", 7'b0101010);
    // save / overwrite / restore
    cyc(1, 1, 6'b000000, 32'h0, 1, 0, 0);
    chk("set_101", 7'b1011010);
    cyc(0, 0, 6'b000000, 32'h0, 0, 1, 0);
    chk("save_one", 7'b1011000);
    cyc(1, 1, 6'b000000, 32'hFFFF_FFFF, 0, 0, 0);
    chk("arith_010", 7'b0101000);
    cyc(0, 0, 6'b000000, 32'h0, 0, 0, 1);
    chk("restore_101", 7'b1011010);
    // fill: A={0,0,1} B={0,1,0} C={1,0,0} D={0,1,1}, saving old flags while latching new
    cyc(1, 1, 6'b000000, 32'h1, 1, 0, 0);
    cyc(1, 1, 6'b000000, 32'h8000_0000, 0, 1, 0);
    chk("save_with_alu", 7'b0101000);
    cyc(1, 1, 6'b000000, 32'h0, 0, 1, 0);
    cyc(1, 1, 6'b000000, 32'h8000_0000, 1, 1, 0);
    cyc(0, 0, 6'b000000, 32'h0, 0, 1, 0);
    chk("stack_full", 7'b0111100);
    cyc(0, 0, 6'b000000, 32'h0, 0, 1, 0);
    chk("overflow_err", 7'b0111101);
    cyc(0, 0, 6'b000000, 32'h0, 0, 0, 1);
    chk("pop_D", 7'b0111001);
    cyc(0, 0, 6'b000000, 32'h0, 0, 0, 1);
    chk("pop_C", 7'b1001001);
    cyc(0, 0, 6'b000000, 32'h0, 0, 0, 1);
    chk("pop_B", 7'b0101001);
    cyc(0, 0, 6'b000000, 32'h0, 0, 0, 1);
    chk("pop_A_empty", 7'b0011011);
    cyc(0, 0, 6'b000000, 32'h0, 0, 0, 1);
    chk("underflow_held", 7'b0011011);
    // build pend=2, sp=3 then reset mid-run
    cyc(1, 0, 6'b000000, 32'h0, 0, 1, 0);
    cyc(1, 0, 6'b000000, 32'h0, 0, 1, 0);
    cyc(0, 0, 6'b000000, 32'h0, 0, 1, 0);
    chk("pre_reset", 7'b0010001);
    do_reset();
    chk("after_reset", 7'b0001010);
    // restore wins over same-cycle ALU update, pending still retires
    cyc(1, 1, 6'b000000, 32'h8000_0000, 1, 0, 0);
    cyc(0, 0, 6'b000000, 32'h0, 0, 1, 0);
    chk("saved_011", 7'b0111000);
    cyc(1, 0, 6'b000000, 32'h0, 0, 0, 0);
    chk("pend_one", 7'b0110000);
    cyc(0, 1, 6'b000000, 32'h0, 0, 0, 1);
    chk("restore_beats_alu", 7'b0111010);
    // save & restore clash
    cyc(0, 0, 6'b000000, 32'h0, 0, 1, 0);
    cyc(0, 0, 6'b000000, 32'h0, 0, 1, 1);
    chk("clash_err", 7'b0111001);
    cyc(0, 0, 6'b000000, 32'h0, 0, 0, 1);
    chk("clash_sp_kept", 7'b0111011);
    // pending overflow
    do_reset();
    repeat (3) cyc(1, 0, 6'b000000, 32'h0, 0, 0, 0);
    chk("pend_max", 7'b0000010);
    cyc(1, 0, 6'b000000, 32'h0, 0, 0, 0);
    chk("pend_overflow", 7'b0000011);
    repeat (2) cyc(0, 1, 6'b001000, 32'h5, 0, 0, 0);
    chk("pend_still_one", 7'b0000011);
    cyc(0, 1, 6'b001000, 32'h5, 0, 0, 0);
    chk("pend_drained", 7'b0001011);
    // pending underflow still updates flags
    do_reset();
    cyc(0, 1, 6'b000000, 32'h0, 0, 0, 0);
    chk("pend_underflow", 7'b1001011);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
